// File: rtl/keypad_scan_if.sv
// Keypad matrix and display-history signals shared by the scan controller and its neighbours.
interface keypad_scan_if;
  logic [3:0] columns;
  logic [3:0] rows;
  logic       key_valid;
  logic [3:0] key_code;
  logic [3:0] digit_new;
  logic [3:0] digit_old;
  logic       key_held;

  modport master (
    input  columns,
    output rows, key_valid, key_code, digit_new, digit_old, key_held
  );

  modport slave (
    output columns,
    input  rows, key_valid, key_code, digit_new, digit_old, key_held
  );
endinterface

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: row strobing, press/release debounce, single-event lockout, two-digit history.
// state        | meaning
// SCAN         | rotate row strobe, look for a low column on the last dwell cycle
// DEBOUNCE     | count stable-low cycles of the captured column
// HELD         | event registered, other keys locked out until release
// RELEASE_WAIT | count stable-high cycles before resuming the scan
module keypad_scan_ctrl #(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 8
) (
  input logic            clk,
  input logic            reset,
  keypad_scan_if.master  bus
);

  localparam int DW = $clog2(SCAN_DIV) + 1;
  localparam int BW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE_WAIT} state_t;

  state_t        state, state_nxt;
  logic [3:0]    sync1, col_sync;
  logic [DW-1:0] dwell_cnt, dwell_nxt;
  logic [BW-1:0] deb_cnt, deb_nxt;
  logic [1:0]    cap_row, cap_row_nxt, cap_col, cap_col_nxt;
  logic [1:0]    row_idx, col_idx;
  logic [3:0]    rows_q, rows_nxt, rows_rot;
  logic          kv_q, kv_nxt, held_q, held_nxt;
  logic [3:0]    code_q, code_nxt, dnew_q, dnew_nxt, dold_q, dold_nxt;
  logic [3:0]    cur_code;
  logic          dwell_done, deb_done, any_low, cap_bit;

  function automatic logic [3:0] key_lut(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'h0: key_lut = 4'h1;  4'h1: key_lut = 4'h2;  4'h2: key_lut = 4'h3;  4'h3: key_lut = 4'hA;
      4'h4: key_lut = 4'h4;  4'h5: key_lut = 4'h5;  4'h6: key_lut = 4'h6;  4'h7: key_lut = 4'hB;
      4'h8: key_lut = 4'h7;  4'h9: key_lut = 4'h8;  4'hA: key_lut = 4'h9;  4'hB: key_lut = 4'hC;
      4'hC: key_lut = 4'hE;  4'hD: key_lut = 4'h0;  4'hE: key_lut = 4'hF;  default: key_lut = 4'hD;
    endcase
  endfunction

  assign dwell_done = (dwell_cnt == DWELL_LAST);
  assign deb_done   = (deb_cnt == DEB_LAST);
  assign any_low    = (col_sync != 4'b1111);
  assign cap_bit    = col_sync[2'd3 - cap_col];
  assign rows_rot   = {rows_q[0], rows_q[3:1]};
  assign cur_code   = key_lut(cap_row, cap_col);

  always_comb begin
    case (rows_q)
      4'b1000: row_idx = 2'd0;
      4'b0100: row_idx = 2'd1;
      4'b0010: row_idx = 2'd2;
      default: row_idx = 2'd3;
    endcase
    // col0 sits on bit 3 and wins when several columns are low
    if (!col_sync[3])      col_idx = 2'd0;
    else if (!col_sync[2]) col_idx = 2'd1;
    else if (!col_sync[1]) col_idx = 2'd2;
    else                   col_idx = 2'd3;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SCAN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SCAN:         if (dwell_done && any_low) state_nxt = DEBOUNCE;
      DEBOUNCE:     if (cap_bit) state_nxt = SCAN;
                    else if (deb_done) state_nxt = HELD;
      HELD:         if (cap_bit) state_nxt = RELEASE_WAIT;
      RELEASE_WAIT: if (!cap_bit) state_nxt = HELD;
                    else if (deb_done) state_nxt = SCAN;
      default:      state_nxt = SCAN;
    endcase
  end

  always_comb begin
    rows_nxt    = rows_q;
    dwell_nxt   = dwell_cnt;
    deb_nxt     = deb_cnt;
    cap_row_nxt = cap_row;
    cap_col_nxt = cap_col;
    kv_nxt      = 1'b0;
    held_nxt    = 1'b0;
    code_nxt    = code_q;
    dnew_nxt    = dnew_q;
    dold_nxt    = dold_q;
    case (state)
      SCAN: begin
        if (dwell_done) begin
          dwell_nxt = '0;
          if (any_low) begin
            cap_row_nxt = row_idx;
            cap_col_nxt = col_idx;
            deb_nxt     = '0;
          end else begin
            rows_nxt = rows_rot;
          end
        end else begin
          dwell_nxt = dwell_cnt + DW'(1);
        end
      end
      DEBOUNCE: begin
        if (cap_bit) begin
          deb_nxt   = '0;
          dwell_nxt = '0;
          rows_nxt  = rows_rot;
        end else if (deb_done) begin
          deb_nxt  = '0;
          kv_nxt   = 1'b1;
          held_nxt = 1'b1;
          code_nxt = cur_code;
          dnew_nxt = cur_code;
          dold_nxt = dnew_q;
        end else begin
          deb_nxt = deb_cnt + BW'(1);
        end
      end
      HELD: begin
        held_nxt = 1'b1;
        if (cap_bit) deb_nxt = '0;
      end
      RELEASE_WAIT: begin
        if (!cap_bit) begin
          held_nxt = 1'b1;
          deb_nxt  = '0;
        end else if (deb_done) begin
          deb_nxt   = '0;
          dwell_nxt = '0;
          rows_nxt  = rows_rot;
        end else begin
          held_nxt = 1'b1;
          deb_nxt  = deb_cnt + BW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= 4'b1111;
      col_sync  <= 4'b1111;
      rows_q    <= 4'b1000;
      dwell_cnt <= '0;
      deb_cnt   <= '0;
      cap_row   <= '0;
      cap_col   <= '0;
      kv_q      <= 1'b0;
      held_q    <= 1'b0;
      code_q    <= '0;
      dnew_q    <= '0;
      dold_q    <= '0;
    end else begin
      sync1     <= bus.columns;
      col_sync  <= sync1;
      rows_q    <= rows_nxt;
      dwell_cnt <= dwell_nxt;
      deb_cnt   <= deb_nxt;
      cap_row   <= cap_row_nxt;
      cap_col   <= cap_col_nxt;
      kv_q      <= kv_nxt;
      held_q    <= held_nxt;
      code_q    <= code_nxt;
      dnew_q    <= dnew_nxt;
      dold_q    <= dold_nxt;
    end
  end

  assign bus.rows      = rows_q;
  assign bus.key_valid = kv_q;
  assign bus.key_held  = held_q;
  assign bus.key_code  = code_q;
  assign bus.digit_new = dnew_q;
  assign bus.digit_old = dold_q;

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
- Sequencing controller for the 4x4 matrix keypad.
- Drives one-hot row strobes, samples the active-low column returns, and debounces the press.
- Registers exactly one key event per physical press and locks out other keys until release.
- Maintains a two-digit history (newest and previous hex key) for the dual seven-segment display path.

Parameters:
- SCAN_DIV, 4, clock cycles each row is driven before advancing (>=4).
- DEBOUNCE_CYCLES, 8, consecutive stable cycles required for press and for release (>=2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- columns  input  4  raw keypad columns, active-low; columns[3]=col0 ... columns[0]=col3
- rows  output  4  one-hot row drive; 4'b1000=row0 ... 4'b0001=row3
- key_valid  output  1  one-cycle pulse when a debounced press is registered
- key_code  output  4  hex code of the last registered key
- digit_new  output  4  most recent key
- digit_old  output  4  key before digit_new
- key_held  output  1  high while a registered key is held or release is debouncing

Behaviour:
- Reset (reset=0, async): rows=4'b1000, key_valid=0, key_code=0, digit_new=0, digit_old=0, key_held=0, state=SCAN, all counters=0.
- Synchronizer: columns passes through a 2-flop synchronizer to give col_sync. Every decision below uses col_sync only, so there are 2 cycles of input latency.
- Key map [row][col]:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D (E=*, F=#)
- SCAN state:
  - Dwell counter runs 0..SCAN_DIV-1 per row.
  - On the last dwell cycle:
    - If col_sync==4'b1111, rows rotates right (1000->0100->0010->0001->1000).
    - Otherwise, capture the row and the lowest-index low column (priority col0=bit3 > bit2 > bit1 > bit0), freeze rows, and go to DEBOUNCE.
  - Col_sync is ignored before the last dwell cycle, which gives settling time after each row change.
- DEBOUNCE state:
  - Counter increments each cycle the captured column bit is low in col_sync.
  - If the bit reads high in any cycle: clear the counter, advance rows to the next row, return to SCAN. No event is produced.
  - When the counter reaches DEBOUNCE_CYCLES:
    - Pulse key_valid for 1 cycle.
    - key_code<=code, digit_old<=digit_new, digit_new<=code (all in the same cycle as the pulse).
    - Go to HELD.
- HELD state:
  - rows stays frozen; key_held=1.
  - Other columns going low are ignored, so no second event is produced.
  - When the captured column bit goes high, go to RELEASE_WAIT.
- RELEASE_WAIT state:
  - key_held=1.
  - Counter increments while the captured bit is high. If the bit goes low again, return to HELD with no new event (bounce on release).
  - When the counter reaches DEBOUNCE_CYCLES: key_held=0, advance rows to the next row, go to SCAN with the dwell counter at 0.
- Registered outputs: all outputs are registered. key_valid is never high for two consecutive cycles.
- Mid-operation reset: an asynchronous assert in any state forces the reset values immediately. Scanning resumes at row0 on the first clk edge after deassert.
- Counter widths: counters are sized by $clog2 of their parameter plus 1, so there is no wrap before the terminal count.

Test Plan:
- Reset and idle: hold reset=0 for 2 cycles, then release with columns=4'b1111. Required: rows=1000 immediately, then 0100 after 4 cycles and 0010 after 8. key_valid stays 0 and key_held stays 0.
- Single press: while rows=0001, drive columns=4'b1110 and hold. Required: one key_valid pulse, 2+8 cycles after the first sampled low. key_code=D and digit_new=D. rows stays frozen at 0001 while the key is held.
- History shift: press '1' (row 1000, columns 0111), release, then press '5' (row 0100, columns 1011). Required: digit_old=1 and digit_new=5. Exactly 2 key_valid pulses in total.
- Bounce rejection:
  - Press '4', toggling columns 0111/1111 every 3 cycles for 30 cycles. Required: no key_valid, and scanning continues.
  - Then hold the key steady. Required: exactly one event with code 4.
- Lockout and release bounce:
  - While '2' is held, also drive col0 low (columns 0011). Required: no new event.
  - Release with a 3-cycle glitch. Required: no new event. key_held drops only after 8 stable high cycles.
- Async reset mid-debounce: assert reset during DEBOUNCE. Required: all outputs return to their reset values without waiting for a clk edge. After release, rows=1000 and the digit outputs are 0.
